// File: rtl/scp_ctrl_pkg.sv
// ==========================================================================
// scp_ctrl_pkg : opcodes, FSM states and strobe bundle for the SCP controller
// Revision 1.0
// ==========================================================================
`default_nettype none

package scp_ctrl_pkg;

  localparam logic [2:0] OP_HALT  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_IN    = 3'b110;
  localparam logic [2:0] OP_OUT   = 3'b111;

  localparam int unsigned TMR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_IO = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  typedef struct packed {
    logic add_sub;
    logic load_acc;
    logic ac_sel;
    logic rd;
    logic wr;
    logic io_mem_sel;
    logic shift;
  } strobe_t;

  // Datapath strobes for the single EXEC cycle of a non-I/O instruction.
  function automatic strobe_t exec_strobes(input logic [2:0] op);
    strobe_t s;
    s = '0;
    case (op)
      OP_LOAD: begin
        s.rd       = 1'b1;
        s.load_acc = 1'b1;
      end
      OP_ADD: begin
        s.rd       = 1'b1;
        s.ac_sel   = 1'b1;
        s.load_acc = 1'b1;
      end
      OP_SUB: begin
        s.rd       = 1'b1;
        s.ac_sel   = 1'b1;
        s.add_sub  = 1'b1;
        s.load_acc = 1'b1;
      end
      OP_SHL: begin
        s.ac_sel   = 1'b1;
        s.shift    = 1'b1;
        s.load_acc = 1'b1;
      end
      OP_STORE: s.wr = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scp_io_timer.sv
// ==========================================================================
// scp_io_timer : loadable down-counter bounding the I/O handshake wait
// Revision 1.0
// ==========================================================================
`default_nettype none

module scp_io_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  input  logic clear,
  output logic expired
);

  logic [W-1:0] count;

  // count holds the wait cycles left including the current one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= W'(TIMEOUT);
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

`default_nettype wire

// File: rtl/scp_controller_n8.sv
// ==========================================================================
// scp_controller_n8 : multi-cycle control FSM for the 8-bit SCP datapath
// Revision 1.0
// ==========================================================================
`default_nettype none

module scp_controller_n8
  import scp_ctrl_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned IO_TIMEOUT = 15,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opCode,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             AddSub,
  output logic             LoadAcc,
  output logic             AcSel,
  output logic             rd,
  output logic             wr,
  output logic             IOMemSel,
  output logic             Shift,
  output logic             pc_start,
  output logic             in_ack,
  output logic             out_valid,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  // N only names the datapath this unit pairs with; no data passes through here.
  if (N < 3) begin : g_narrow_datapath
  end

  state_t     state_q, state_d;
  logic [2:0] op_q;
  strobe_t    strobe_q, strobe_d;
  logic       pc_start_d, in_ack_d, out_valid_d;
  logic       tmr_load, tmr_dec, tmr_clear, tmr_expired;

  scp_io_timer #(
    .TIMEOUT (IO_TIMEOUT),
    .W       (TMR_W)
  ) u_io_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .dec     (tmr_dec),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d     = state_q;
    strobe_d    = '0;
    in_ack_d    = 1'b0;
    out_valid_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (opCode == OP_HALT) begin
          state_d = ST_HALT;
        end else if ((opCode == OP_IN) || (opCode == OP_OUT)) begin
          state_d  = ST_WAIT_IO;
          tmr_load = 1'b1;
          if (opCode == OP_OUT) begin
            strobe_d.rd = 1'b1;
            out_valid_d = 1'b1;
          end
        end else begin
          state_d  = ST_EXEC;
          strobe_d = exec_strobes(opCode);
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WAIT_IO: begin
        if (op_q == OP_IN) begin
          // A registered in_ack marks the write cycle that follows the handshake.
          if (in_ack) begin
            state_d = ST_WB;
          end else if (in_valid) begin
            strobe_d.wr         = 1'b1;
            strobe_d.io_mem_sel = 1'b1;
            in_ack_d            = 1'b1;
            tmr_clear           = 1'b1;
          end else if (tmr_expired) begin
            state_d = ST_ERR;
          end else begin
            tmr_dec = 1'b1;
          end
        end else begin
          if (out_ready) begin
            state_d   = ST_WB;
            tmr_clear = 1'b1;
          end else if (tmr_expired) begin
            state_d = ST_ERR;
          end else begin
            strobe_d.rd = 1'b1;
            out_valid_d = 1'b1;
            tmr_dec     = 1'b1;
          end
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase

    pc_start_d = (state_d == ST_WB);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_HALT;
      strobe_q  <= '0;
      pc_start  <= 1'b0;
      in_ack    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      pc_start  <= pc_start_d;
      in_ack    <= in_ack_d;
      out_valid <= out_valid_d;
      busy      <= (state_d != ST_IDLE) && (state_d != ST_HALT) && (state_d != ST_ERR);
      halted    <= (state_d == ST_HALT);
      err       <= (state_d == ST_ERR);
      if (state_q == ST_DECODE) begin
        op_q <= opCode;
      end
      if ((state_d == ST_WB) && (instr_cnt != {CNT_W{1'b1}})) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

  assign AddSub   = strobe_q.add_sub;
  assign LoadAcc  = strobe_q.load_acc;
  assign AcSel    = strobe_q.ac_sel;
  assign rd       = strobe_q.rd;
  assign wr       = strobe_q.wr;
  assign IOMemSel = strobe_q.io_mem_sel;
  assign Shift    = strobe_q.shift;

endmodule

`default_nettype wire

// File: tb/tb_scp_controller_n8.sv
// ==========================================================================
// tb_scp_controller_n8 : scoreboard bench for the SCP control unit
// Revision 1.0
// ==========================================================================
`default_nettype none

module tb_scp_controller_n8;
  import scp_ctrl_pkg::*;

  localparam int CNT_W = 8;

  // Snapshot bit positions: {AddSub,LoadAcc,AcSel,rd,wr,IOMemSel,Shift,pc_start,in_ack,out_valid,err,halted}
  localparam logic [11:0] S_ADDSUB = 12'h800;
  localparam logic [11:0] S_LOADAC = 12'h400;
  localparam logic [11:0] S_ACSEL  = 12'h200;
  localparam logic [11:0] S_RD     = 12'h100;
  localparam logic [11:0] S_WR     = 12'h080;
  localparam logic [11:0] S_IOMEM  = 12'h040;
  localparam logic [11:0] S_SHIFT  = 12'h020;
  localparam logic [11:0] S_PC     = 12'h010;
  localparam logic [11:0] S_INACK  = 12'h008;
  localparam logic [11:0] S_OUTV   = 12'h004;
  localparam logic [11:0] S_ERR    = 12'h002;
  localparam logic [11:0] S_HALT   = 12'h001;

  logic             clk;
  logic             reset, start, in_valid, out_ready;
  logic [2:0]       opCode;
  logic             AddSub, LoadAcc, AcSel, rd, wr, IOMemSel, Shift;
  logic             pc_start, in_ack, out_valid, busy, halted, err;
  logic [CNT_W-1:0] instr_cnt;

  scp_controller_n8 #(.N(8), .IO_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .opCode(opCode),
    .in_valid(in_valid), .out_ready(out_ready),
    .AddSub(AddSub), .LoadAcc(LoadAcc), .AcSel(AcSel), .rd(rd), .wr(wr),
    .IOMemSel(IOMemSel), .Shift(Shift), .pc_start(pc_start), .in_ack(in_ack),
    .out_valid(out_valid), .busy(busy), .halted(halted), .err(err),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] sig;
    logic [7:0]  cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;
  logic prev_err = 1'b0;
  logic prev_halt = 1'b0;

  function automatic logic [11:0] snap();
    return {AddSub, LoadAcc, AcSel, rd, wr, IOMemSel, Shift, pc_start, in_ack, out_valid, err, halted};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] sig, input int cnt, input string name);
    exp_t e;
    e.sig  = sig;
    e.cnt  = 8'(cnt);
    e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [11:0] exec_exp(input logic [2:0] op);
    case (op)
      OP_LOAD:  return S_RD | S_LOADAC;
      OP_STORE: return S_WR;
      OP_ADD:   return S_RD | S_ACSEL | S_LOADAC;
      OP_SUB:   return S_RD | S_ACSEL | S_ADDSUB | S_LOADAC;
      OP_SHL:   return S_ACSEL | S_SHIFT | S_LOADAC;
      default:  return 12'h000;
    endcase
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // Monitor: pops one expectation whenever the DUT shows a strobe, pulse, transfer or trap entry.
  initial begin
    logic [11:0] s;
    logic        fire;
    exp_t        e;
    forever begin
      @(negedge clk);
      s    = snap();
      fire = (((s & 12'hFFC) != 12'h000) && !(out_valid && !out_ready))
             || (err && !prev_err) || (halted && !prev_halt);
      prev_err  = err;
      prev_halt = halted;
      if (fire) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got sig=0x%03h cnt=%0d, expected nothing", s, instr_cnt);
        end else begin
          e = sb.pop_front();
          check({e.name, "_sig"}, 32'(s), 32'(e.sig));
          check({e.name, "_cnt"}, 32'(instr_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // All instruction tasks start and end in a FETCH cycle, 1 time unit after the edge.
  task automatic exec_op(input logic [2:0] op, input bit scramble);
    opCode = op;
    push(exec_exp(op), exp_cnt, "exec");
    exp_cnt = sat_inc(exp_cnt);
    push(S_PC, exp_cnt, "wb");
    tick();
    tick();
    if (scramble) opCode = ~op;
    tick();
    tick();
  endtask

  task automatic in_op(input int delay);
    opCode = OP_IN;
    push(S_WR | S_IOMEM | S_INACK, exp_cnt, "in_ack");
    exp_cnt = sat_inc(exp_cnt);
    push(S_PC, exp_cnt, "in_wb");
    tick();
    tick();
    repeat (delay) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("in_no_err", 32'(err), 32'(0));
    tick();
  endtask

  task automatic out_op(input int hs_cycle);
    opCode = OP_OUT;
    push(S_RD | S_OUTV, exp_cnt, "out_xfer");
    exp_cnt = sat_inc(exp_cnt);
    push(S_PC, exp_cnt, "out_wb");
    tick();
    tick();
    repeat (hs_cycle - 1) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  task automatic halt_op();
    opCode = OP_HALT;
    push(S_HALT, exp_cnt, "halt");
    tick();
    tick();
    check("halt_halted", 32'(halted), 32'(1));
    check("halt_busy", 32'(busy), 32'(0));
    repeat (3) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
    end
    check("halt_absorbing", 32'({halted, busy}), 32'(2));
    check("halt_cnt_frozen", 32'(instr_cnt), 32'(exp_cnt));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < 40)) begin
      tick();
      n++;
    end
    check(name, 32'(sb.size()), 32'(0));
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_cnt   = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic begin_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    opCode    = OP_HALT;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'(snap()), 32'(0));
    check("reset_busy_cnt", 32'({busy, instr_cnt}), 32'(0));
    reset = 1'b1;
    repeat (3) tick();
    check("idle_without_start", 32'(busy), 32'(0));

    // Reset asserted in the EXEC cycle of an ADD
    opCode = OP_ADD;
    begin_run();
    tick();
    tick();
    check("exec_before_reset", 32'(snap()), 32'(S_RD | S_ACSEL | S_LOADAC));
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'(snap()), 32'(0));
    check("async_reset_busy_cnt", 32'({busy, instr_cnt}), 32'(0));
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("idle_after_reset", 32'({busy, snap()}), 32'(0));

    // Mixed program ending in HALT
    begin_run();
    exec_op(OP_ADD, 1'b0);
    check("cnt_after_add", 32'(instr_cnt), 32'(1));
    exec_op(OP_SUB, 1'b0);
    exec_op(OP_LOAD, 1'b0);
    exec_op(OP_STORE, 1'b1);
    exec_op(OP_SHL, 1'b1);
    in_op(3);
    in_op(0);
    in_op(14);
    out_op(1);
    out_op(15);
    halt_op();
    drain("prog_drain");
    do_reset();

    // OUT with no sink response traps after 15 wait cycles
    begin_run();
    opCode = OP_OUT;
    push(S_ERR, exp_cnt, "out_timeout");
    tick();
    tick();
    repeat (14) tick();
    check("out_cycle15_no_err", 32'({err, out_valid}), 32'(1));
    tick();
    check("out_timeout_err", 32'({err, out_valid, busy}), 32'(4));
    repeat (3) tick();
    check("err_absorbing", 32'(err), 32'(1));
    drain("timeout_drain");
    do_reset();
    check("err_cleared_by_reset", 32'(err), 32'(0));

    // Counter saturation with opCode disturbed during some EXEC cycles
    begin_run();
    for (int i = 0; i < 300; i++) begin
      exec_op(OP_ADD, (i % 7) == 3);
    end
    check("cnt_saturated", 32'(instr_cnt), 32'(255));
    halt_op();
    drain("sat_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
